// File: rtl/umi_mem_responder.sv
// ---------------------------------------------------------------------------
// umi_mem_responder
//
// Purpose:
//   UMI device-side memory target. Accepts one UMI request at a time, services
//   it against an internal word-addressed memory of DEPTH words of DW bits,
//   and returns a UMI response for reads and non-posted writes. Posted writes
//   complete silently at one per cycle. Unsupported opcodes are consumed and
//   discarded.
//
// Ports:
//   clk           in   1    clock, rising edge
//   rst           in   1    synchronous active-high reset
//   req_valid     in   1    request valid
//   req_ready     out  1    request ready (only in IDLE, low during reset)
//   req_cmd       in   CW   request command, opcode in [4:0]
//   req_dstaddr   in   AW   target byte address
//   req_srcaddr   in   AW   requester return address
//   req_data      in   DW   write data
//   resp_valid    out  1    response valid
//   resp_ready    in   1    response ready
//   resp_cmd      out  CW   response command
//   resp_dstaddr  out  AW   response destination (request srcaddr)
//   resp_srcaddr  out  AW   response source (request dstaddr)
//   resp_data     out  DW   read data, zero for write responses
//   err_count     out  8    unsupported-request counter
//
// Configuration:
//   UMI_MEM_RESP_ERRCNT_EN  when defined, err_count counts discarded
//                           unsupported requests (saturating at 0xFF);
//                           otherwise err_count is tied to zero.
// ---------------------------------------------------------------------------
module umi_mem_responder #(
  parameter int DW    = 64,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_cmd,
  input  logic [AW-1:0] req_dstaddr,
  input  logic [AW-1:0] req_srcaddr,
  input  logic [DW-1:0] req_data,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [CW-1:0] resp_cmd,
  output logic [AW-1:0] resp_dstaddr,
  output logic [AW-1:0] resp_srcaddr,
  output logic [DW-1:0] resp_data,
  output logic [7:0]    err_count
);

  localparam int IDX_LSB = $clog2(DW / 8);
  localparam int IW      = $clog2(DEPTH);

  localparam logic [4:0] OP_REQ_READ   = 5'h01;
  localparam logic [4:0] OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0] OP_REQ_POSTED = 5'h05;
  localparam logic [4:0] OP_RESP_READ  = 5'h02;
  localparam logic [4:0] OP_RESP_WRITE = 5'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdData;

  logic [CW-1:0] r_respCmd;
  logic [AW-1:0] r_respDstAddr;
  logic [AW-1:0] r_respSrcAddr;
  logic [DW-1:0] r_respData;

  logic [4:0]    w_opcode;
  logic [IW-1:0] w_idx;
  logic          w_accept;
  logic          w_isRead;
  logic          w_isWrite;
  logic          w_isPosted;
  logic          w_unusedAddr;

  // Byte-offset bits below the word and address bits above the memory are
  // dropped, so out-of-range addresses wrap modulo DEPTH.
  assign w_opcode     = req_cmd[4:0];
  assign w_idx        = req_dstaddr[IDX_LSB +: IW];
  assign w_unusedAddr = ^req_dstaddr;

  assign w_accept   = req_valid & req_ready;
  assign w_isRead   = (w_opcode == OP_REQ_READ);
  assign w_isWrite  = (w_opcode == OP_REQ_WRITE);
  assign w_isPosted = (w_opcode == OP_REQ_POSTED);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: reads take an extra cycle for the synchronous memory
  // read; posted writes and unsupported requests never leave IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_isRead) begin
          w_nextState = ST_RD;
        end else if (w_accept && w_isWrite) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RD:   w_nextState = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output logic: req_ready is gated by rst so nothing is accepted while the
  // block is held in reset.
  always_comb begin
    req_ready  = (r_state == ST_IDLE) && !rst;
    resp_valid = (r_state == ST_RESP);
  end

  // Memory array. Not reset; w_accept is already low during reset, so a
  // reset can never leave a partial write behind.
  always_ff @(posedge clk) begin
    if (w_accept && (w_isWrite || w_isPosted)) begin
      r_mem[w_idx] <= req_data;
    end
    if (w_accept && w_isRead) begin
      r_rdData <= r_mem[w_idx];
    end
  end

  // Response register file. Fields are loaded at the request handshake and
  // then held until the next accepted request, which keeps them stable
  // throughout any response backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_respCmd     <= '0;
      r_respDstAddr <= '0;
      r_respSrcAddr <= '0;
      r_respData    <= '0;
    end else begin
      if (w_accept && w_isRead) begin
        r_respCmd     <= {req_cmd[CW-1:5], OP_RESP_READ};
        r_respDstAddr <= req_srcaddr;
        r_respSrcAddr <= req_dstaddr;
      end else if (w_accept && w_isWrite) begin
        r_respCmd     <= {req_cmd[CW-1:5], OP_RESP_WRITE};
        r_respDstAddr <= req_srcaddr;
        r_respSrcAddr <= req_dstaddr;
        r_respData    <= '0;
      end
      if (r_state == ST_RD) begin
        r_respData <= r_rdData;
      end
    end
  end

  assign resp_cmd     = r_respCmd;
  assign resp_dstaddr = r_respDstAddr;
  assign resp_srcaddr = r_respSrcAddr;
  assign resp_data    = r_respData;

`ifdef UMI_MEM_RESP_ERRCNT_EN
  logic [7:0] r_errCount;
  logic       w_isUnsup;

  assign w_isUnsup = !(w_isRead || w_isWrite || w_isPosted);

  // Saturating count of discarded unsupported requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_errCount <= 8'h00;
    end else if (w_accept && w_isUnsup && (r_errCount != 8'hFF)) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  assign err_count = r_errCount;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_umi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_umi_mem_responder
//
// Self-checking bench for umi_mem_responder (DW=64, AW=64, CW=32, DEPTH=256).
// Keeps a plain word-array memory model and a saturating error-count model;
// expected response fields come from the UMI request/response rules.
// ---------------------------------------------------------------------------
module tb_umi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_cmd;
  logic [63:0] req_dstaddr;
  logic [63:0] req_srcaddr;
  logic [63:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_cmd;
  logic [63:0] resp_dstaddr;
  logic [63:0] resp_srcaddr;
  logic [63:0] resp_data;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [256];
  int          errModel = 0;
  bit          errEnabled;

  umi_mem_responder #(
    .DW(64), .AW(64), .CW(32), .DEPTH(256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_dstaddr  (req_dstaddr),
    .req_srcaddr  (req_srcaddr),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_cmd     (resp_cmd),
    .resp_dstaddr (resp_dstaddr),
    .resp_srcaddr (resp_srcaddr),
    .resp_data    (resp_data),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word index from a byte address: drop 3 byte-offset bits, wrap mod 256.
  function automatic int wordOf(input logic [63:0] addr);
    return int'((addr >> 3) % 64'd256);
  endfunction

  function automatic void bumpErrModel();
    if (errEnabled && errModel < 255) errModel++;
  endfunction

  // Present a request and hold it until the handshake edge has passed.
  // Returns just after the handshake edge with req_valid dropped.
  task automatic applyStimulus(input logic [31:0] cmd, input logic [63:0] dst,
                               input logic [63:0] src, input logic [63:0] data);
    int waited;
    waited      = 0;
    req_cmd     = cmd;
    req_dstaddr = dst;
    req_srcaddr = src;
    req_data    = data;
    req_valid   = 1'b1;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("[TB] FAIL req_accept_timeout got req_ready=%0b exp 1 cmd=%h", req_ready, cmd);
    end else begin
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req_ready got %b exp 0", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_resp_valid got %b exp 0", resp_valid);
    end
    checks++;
    if ({resp_cmd, resp_dstaddr, resp_srcaddr, resp_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_resp_fields got cmd=%h dst=%h src=%h data=%h exp all 0",
               resp_cmd, resp_dstaddr, resp_srcaddr, resp_data);
    end
    checks++;
    if (err_count !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_err_count got %h exp 00", err_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset_req_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] cmd;
    cmd = {27'h2A5_5A5A, 5'h03};
    applyStimulus(cmd, 64'h40, 64'h1000, 64'hDEADBEEF_CAFEF00D);
    model[wordOf(64'h40)] = 64'hDEADBEEF_CAFEF00D;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL write_latency got resp_valid=%b exp 1", resp_valid);
    end
    checks++;
    if (resp_cmd !== {cmd[31:5], 5'h04} || resp_dstaddr !== 64'h1000 ||
        resp_srcaddr !== 64'h40 || resp_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL write_resp got cmd=%h dst=%h src=%h data=%h exp cmd=%h dst=1000 src=40 data=0",
               resp_cmd, resp_dstaddr, resp_srcaddr, resp_data, {cmd[31:5], 5'h04});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_back_to_idle got req_ready=%b resp_valid=%b exp 1 0", req_ready, resp_valid);
    end

    cmd = {27'h000_1234, 5'h01};
    applyStimulus(cmd, 64'h40, 64'h2000, 64'h0);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_rd_cycle got resp_valid=%b req_ready=%b exp 0 0", resp_valid, req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_cmd !== {cmd[31:5], 5'h02} || resp_dstaddr !== 64'h2000 ||
        resp_srcaddr !== 64'h40 || resp_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("[TB] FAIL read_resp got v=%b cmd=%h dst=%h src=%h data=%h exp v=1 cmd=%h dst=2000 src=40 data=deadbeefcafef00d",
               resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data, {cmd[31:5], 5'h02});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_alias();
    applyStimulus({27'h0, 5'h05}, 64'h800, 64'h3000, 64'h55);
    model[wordOf(64'h800)] = 64'h55;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL posted_no_resp got resp_valid=%b req_ready=%b exp 0 1", resp_valid, req_ready);
    end
    // Read immediately after the posted write, at an aliased address.
    applyStimulus({27'h0, 5'h01}, 64'h0, 64'h4000, 64'h0);
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h55) begin
      errors++;
      $display("[TB] FAIL alias_read got v=%b data=%h exp v=1 data=55", resp_valid, resp_data);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] cmd;
    int          stableBad;
    cmd = {27'h7FF_FFFF, 5'h01};
    applyStimulus(cmd, 64'h47, 64'h5555, 64'h0);
    // Hold a competing request on the bus; it must not be taken.
    req_valid   = 1'b1;
    req_cmd     = {27'h0, 5'h05};
    req_dstaddr = 64'h40;
    req_data    = 64'h1111;
    stableBad   = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_cmd !== {cmd[31:5], 5'h02} ||
          resp_dstaddr !== 64'h5555 || resp_srcaddr !== 64'h47 ||
          resp_data !== model[wordOf(64'h47)]) begin
        stableBad++;
      end
    end
    checks++;
    if (stableBad != 0) begin
      errors++;
      $display("[TB] FAIL backpressure_stable got %0d bad cycles exp 0 (last v=%b rdy=%b data=%h)",
               stableBad, resp_valid, req_ready, resp_data);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_release got req_ready=%b resp_valid=%b exp 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_unsupported();
    int respSeen;
    respSeen = 0;
    for (int n = 0; n < 300; n++) begin
      applyStimulus({27'(n), 5'h07}, 64'(n * 8), 64'h6000, 64'hFFFF);
      bumpErrModel();
      if (resp_valid !== 1'b0) respSeen++;
      if (n == 9) begin
        checks++;
        if (err_count !== 8'(errModel)) begin
          errors++; $display("[TB] FAIL err_count_10 got %h exp %h", err_count, 8'(errModel));
        end
      end
    end
    checks++;
    if (respSeen != 0) begin
      errors++; $display("[TB] FAIL unsupported_no_resp got %0d responses exp 0", respSeen);
    end
    checks++;
    if (err_count !== (errEnabled ? 8'hFF : 8'h00)) begin
      errors++;
      $display("[TB] FAIL err_count_sat got %h exp %h", err_count, errEnabled ? 8'hFF : 8'h00);
    end
  endtask

  task automatic test_reset_mid_read();
    int riseCount;
    riseCount = 0;
    applyStimulus({27'h0, 5'h01}, 64'h40, 64'h7000, 64'h0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid !== 1'b0) riseCount++;
    end
    rst = 1'b0;
    errModel = 0;
    tick();
    if (resp_valid !== 1'b0) riseCount++;
    checks++;
    if (riseCount != 0) begin
      errors++; $display("[TB] FAIL reset_mid_read_resp got %0d cycles with resp_valid exp 0", riseCount);
    end
    checks++;
    if (req_ready !== 1'b1 || err_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid_read_idle got req_ready=%b err_count=%h exp 1 00", req_ready, err_count);
    end
    applyStimulus({27'h0, 5'h01}, 64'h40, 64'h7008, 64'h0);
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== model[wordOf(64'h40)] || resp_dstaddr !== 64'h7008) begin
      errors++;
      $display("[TB] FAIL reset_fresh_read got v=%b data=%h dst=%h exp v=1 data=%h dst=7008",
               resp_valid, resp_data, resp_dstaddr, model[wordOf(64'h40)]);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0]  unsupOps [6];
    logic [4:0]  op;
    logic [31:0] cmd;
    logic [63:0] dst, src, data, expData;
    int          kind, delay, postedBad;
    unsupOps  = '{5'h00, 5'h02, 5'h04, 5'h06, 5'h07, 5'h1F};
    postedBad = 0;

    // Fill every word with posted writes, one per cycle.
    for (int w = 0; w < 256; w++) begin
      data = {$urandom, $urandom};
      applyStimulus({27'h0, 5'h05}, 64'(w) << 3, 64'h0, data);
      model[w] = data;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) postedBad++;
    end
    checks++;
    if (postedBad != 0) begin
      errors++; $display("[TB] FAIL posted_fill_rate got %0d stalls exp 0", postedBad);
    end

    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3)      op = 5'h01;
      else if (kind <= 5) op = 5'h03;
      else if (kind <= 7) op = 5'h05;
      else                op = unsupOps[$urandom_range(0, 5)];
      cmd  = {27'($urandom), op};
      dst  = {$urandom, $urandom};
      src  = {$urandom, $urandom};
      data = {$urandom, $urandom};
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      applyStimulus(cmd, dst, src, data);

      if (op == 5'h03 || op == 5'h05) model[wordOf(dst)] = data;
      if (op != 5'h01 && op != 5'h03 && op != 5'h05) bumpErrModel();

      if (op == 5'h01 || op == 5'h03) begin
        expData = (op == 5'h01) ? model[wordOf(dst)] : 64'h0;
        if (op == 5'h01) begin
          checks++;
          if (resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rand_read_latency n=%0d got resp_valid=%b exp 0", n, resp_valid);
          end
          tick();
        end
        delay = $urandom_range(0, 3);
        for (int d = 0; d < delay; d++) tick();
        checks++;
        if (resp_valid !== 1'b1 ||
            resp_cmd !== {cmd[31:5], (op == 5'h01) ? 5'h02 : 5'h04} ||
            resp_dstaddr !== src || resp_srcaddr !== dst || resp_data !== expData) begin
          errors++;
          $display("[TB] FAIL rand_resp n=%0d got v=%b cmd=%h dst=%h src=%h data=%h exp v=1 cmd=%h dst=%h src=%h data=%h",
                   n, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
                   {cmd[31:5], (op == 5'h01) ? 5'h02 : 5'h04}, src, dst, expData);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
      end else begin
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rand_no_resp n=%0d op=%h got resp_valid=%b req_ready=%b exp 0 1",
                   n, op, resp_valid, req_ready);
        end
      end
    end
    checks++;
    if (err_count !== 8'(errModel)) begin
      errors++; $display("[TB] FAIL rand_err_count got %h exp %h", err_count, 8'(errModel));
    end
  endtask

  initial begin
`ifdef UMI_MEM_RESP_ERRCNT_EN
    errEnabled = 1'b1;
`else
    errEnabled = 1'b0;
`endif
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_cmd     = '0;
    req_dstaddr = '0;
    req_srcaddr = '0;
    req_data    = '0;
    resp_ready  = 1'b0;
    for (int w = 0; w < 256; w++) model[w] = '0;
    #1;
    test_reset();
    test_write_read();
    test_alias();
    test_backpressure();
    test_unsupported();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
